parc_core_rob_unit: RTL
=======================

Name: parc_core_rob_unit

Overview:
- Parametrised reorder buffer for the PARCv2 in-order-issue / out-of-order-completion pipeline.
- Decode allocates slots in program order and the writeback stage fills slots out of order.
- Entries commit to the register file in order from the head, one per cycle.
- Two register-address lookup ports give decode youngest-producer bypass information (slot, ready, data), replacing the fixed-size ROB with external slot tracking.

Parameters:
p_depth, 16, number of ROB entries; power of two, 2..32
p_slot_nbits, 4, slot index width; must equal log2(p_depth)
p_data_nbits, 32, result data width
p_addr_nbits, 5, register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc_val  in  1  decode requests a slot
alloc_rdy  out  1  ROB can accept an allocation
alloc_wen  in  1  allocated instruction writes the RF
alloc_waddr  in  p_addr_nbits  destination register
alloc_slot  out  p_slot_nbits  slot granted (current tail)
fill_val  in  1  writeback result valid
fill_slot  in  p_slot_nbits  slot being filled
fill_data  in  p_data_nbits  result value
commit_val  out  1  head entry commits this cycle
commit_slot  out  p_slot_nbits  head slot
commit_rf_wen  out  1  RF write enable for committing entry
commit_waddr  out  p_addr_nbits  RF write address
commit_data  out  p_data_nbits  RF write data
flush  in  1  discard all entries
lookup0_addr, lookup1_addr  in  p_addr_nbits  source registers to search
lookup0_hit, lookup1_hit  out  1  a pending producer exists
lookup0_slot, lookup1_slot  out  p_slot_nbits  youngest producer slot
lookup0_ready, lookup1_ready  out  1  producer already filled
lookup0_data, lookup1_data  out  p_data_nbits  producer data (valid when ready)
occupancy  out  p_slot_nbits+1  number of live entries

Behaviour:
- Per-entry state: valid, filled, wen, waddr, data. head/tail pointers are p_slot_nbits+1 wide; the extra bit is the wrap bit. full = (slot bits equal, wrap bits differ); empty = (head == tail).
- Reset: head = tail = 0, all valid = 0 and filled = 0. Outputs: alloc_rdy = 1, commit_val = 0, lookup*_hit = 0, occupancy = 0, alloc_slot = 0.
- Allocation:
  - alloc_rdy = !full, computed from the current-cycle count only. A same-cycle commit does not free space for an allocation.
  - Fires when alloc_val && alloc_rdy. The entry at tail becomes valid = 1, filled = 0, wen/waddr latched. tail increments at the clock edge.
  - alloc_slot is combinational and equals tail[p_slot_nbits-1:0].
- Fill:
  - When fill_val is high and entry[fill_slot] is valid and not filled: data is latched and filled = 1 at the edge.
  - A fill to an invalid or already-filled slot is ignored and leaves state unchanged.
- Commit:
  - commit_val = head valid && head filled; no backpressure.
  - commit_rf_wen = commit_val && wen && waddr != 0.
  - On commit, head is cleared (valid = 0) and head increments.
  - Entries allocated with alloc_wen = 0 (stores, branches) still occupy a slot and commit with commit_rf_wen = 0.
- Lookup (combinational, per port):
  - Search valid entries with wen = 1 and waddr == lookup addr; addr 0 never hits.
  - Select the youngest match, i.e. the one nearest tail in age order, correct across wrap-around.
  - ready = filled; data = entry data.
  - Same-cycle alloc or fill does not affect lookup results.
  - An entry committing this cycle still reports hit, since the RF write lands at the edge.
- Simultaneous alloc + fill + commit in one cycle are all legal. Allocation to the tail and commit from the head never conflict because alloc is blocked when full.
- Flush:
  - At the edge: all valid = 0, filled = 0, head = tail = 0.
  - Flush dominates a same-cycle alloc, fill or commit. commit_val is still driven combinationally that cycle, and the RF write occurs.
- Reset asserted mid-operation behaves identically to flush plus output reset values.
- occupancy = tail - head (full width). It reads p_depth when full.

Optional Feature:
- Macro: PARC_ROB_FILL_COMMIT_BYPASS_EN.
- Defined: if the head entry is valid and unfilled and fill_val targets the head slot in the same cycle, commit_val = 1 that cycle with commit_data = fill_data. The entry retires and head advances at the edge. lookup ports also report ready = 1 with data = fill_data for a same-cycle fill to the matched slot.
- Undefined: a filled head commits no earlier than the cycle after its fill (minimum fill-to-commit latency of 1).

Test Plan:
- Reset, then alloc r3 and fill slot 0 with 0xDEAD → commit_val = 1 next cycle (same cycle with macro), commit_waddr = 3, commit_data = 0xDEAD, occupancy returns to 0.
- Alloc 16 entries (depth 16) without fills → alloc_rdy = 0 and occupancy = 16. Fill slot 0 → one commit, then alloc_rdy = 1; the next alloc_slot is 0, which exercises wrap.
- Alloc slots 0,1,2 → r5, r7, r5; fill 2 then 1 → no commit until slot 0 is filled. Commits then occur in order 0,1,2 on consecutive cycles.
- With slots 0 and 2 both writing r5, lookup0_addr = 5 → hit = 1, slot = 2. After slot 2 is filled with 0x11 → ready = 1, data = 0x11. lookup1_addr = 0 → hit = 0.
- Alloc with alloc_wen = 0 and fill it → commit_val = 1, commit_rf_wen = 0. An alloc to r0 → commit_rf_wen = 0.
- Issue 5 allocs, then assert flush together with alloc_val → occupancy = 0, all lookups miss, and the next alloc_slot = 0. A later fill to the old slot 3 is ignored.

Source files
------------

// File: rtl/parc_core_rob_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// parc_core_rob_unit : reorder buffer. Slots are allocated and committed in
// order, filled out of order, with two youngest-producer lookup ports.
// Optional feature macro: PARC_ROB_FILL_COMMIT_BYPASS_EN (fill-to-commit bypass).
// Revision: 1.0
//------------------------------------------------------------------------------
module parc_core_rob_unit #(
  parameter int p_depth      = 16,
  parameter int p_slot_nbits = 4,
  parameter int p_data_nbits = 32,
  parameter int p_addr_nbits = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_val,
  output logic                    alloc_rdy,
  input  logic                    alloc_wen,
  input  logic [p_addr_nbits-1:0] alloc_waddr,
  output logic [p_slot_nbits-1:0] alloc_slot,
  input  logic                    fill_val,
  input  logic [p_slot_nbits-1:0] fill_slot,
  input  logic [p_data_nbits-1:0] fill_data,
  output logic                    commit_val,
  output logic [p_slot_nbits-1:0] commit_slot,
  output logic                    commit_rf_wen,
  output logic [p_addr_nbits-1:0] commit_waddr,
  output logic [p_data_nbits-1:0] commit_data,
  input  logic                    flush,
  input  logic [p_addr_nbits-1:0] lookup0_addr,
  input  logic [p_addr_nbits-1:0] lookup1_addr,
  output logic                    lookup0_hit,
  output logic                    lookup1_hit,
  output logic [p_slot_nbits-1:0] lookup0_slot,
  output logic [p_slot_nbits-1:0] lookup1_slot,
  output logic                    lookup0_ready,
  output logic                    lookup1_ready,
  output logic [p_data_nbits-1:0] lookup0_data,
  output logic [p_data_nbits-1:0] lookup1_data,
  output logic [p_slot_nbits:0]   occupancy
);

  logic [p_slot_nbits:0]   head_q, head_d, tail_q, tail_d;
  logic [p_depth-1:0]      valid_q, filled_q, wen_q;
  logic [p_addr_nbits-1:0] waddr_q [p_depth];
  logic [p_data_nbits-1:0] data_q  [p_depth];
  logic [p_slot_nbits-1:0] head_slot, tail_slot;
  logic                    full, alloc_fire, fill_ok, commit_bypass;
  logic [p_addr_nbits-1:0] lk_addr [2];

  assign head_slot  = head_q[p_slot_nbits-1:0];
  assign tail_slot  = tail_q[p_slot_nbits-1:0];
  assign full       = (head_slot == tail_slot) && (head_q[p_slot_nbits] != tail_q[p_slot_nbits]);
  assign alloc_rdy  = !full;
  assign alloc_fire = alloc_val && !full;
  assign alloc_slot = tail_slot;
  assign occupancy  = tail_q - head_q;
  assign fill_ok    = fill_val && valid_q[fill_slot] && !filled_q[fill_slot];

`ifdef PARC_ROB_FILL_COMMIT_BYPASS_EN
  assign commit_bypass = fill_ok && (fill_slot == head_slot);
`else
  assign commit_bypass = 1'b0;
`endif

  assign commit_val    = valid_q[head_slot] && (filled_q[head_slot] || commit_bypass);
  assign commit_slot   = head_slot;
  assign commit_waddr  = waddr_q[head_slot];
  assign commit_data   = commit_bypass ? fill_data : data_q[head_slot];
  assign commit_rf_wen = commit_val && wen_q[head_slot] && (waddr_q[head_slot] != '0);

  assign head_d = head_q + {{p_slot_nbits{1'b0}}, commit_val};
  assign tail_d = tail_q + {{p_slot_nbits{1'b0}}, alloc_fire};

  // Commit clears last so a bypassed fill of the head still retires it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
      filled_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (alloc_fire) begin
        valid_q[tail_slot]  <= 1'b1;
        filled_q[tail_slot] <= 1'b0;
      end
      if (fill_ok) filled_q[fill_slot] <= 1'b1;
      if (commit_val) begin
        valid_q[head_slot]  <= 1'b0;
        filled_q[head_slot] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      wen_q[tail_slot]   <= alloc_wen;
      waddr_q[tail_slot] <= alloc_waddr;
    end
    if (fill_ok) data_q[fill_slot] <= fill_data;
  end

  assign lk_addr[0] = lookup0_addr;
  assign lk_addr[1] = lookup1_addr;

  // Scan oldest to youngest from head so the last match is the youngest.
  for (genvar p = 0; p < 2; p++) begin : g_lookup
    logic                    hit;
    logic [p_slot_nbits-1:0] slot;
    logic                    ready;
    logic [p_data_nbits-1:0] data;

    always_comb begin
      logic [p_slot_nbits-1:0] idx;
      hit   = 1'b0;
      slot  = '0;
      ready = 1'b0;
      data  = '0;
      idx   = '0;
      for (int i = 0; i < p_depth; i++) begin
        idx = head_slot + i[p_slot_nbits-1:0];
        if (valid_q[idx] && wen_q[idx] && (waddr_q[idx] == lk_addr[p]) && (lk_addr[p] != '0)) begin
          hit  = 1'b1;
          slot = idx;
        end
      end
      if (hit) begin
        ready = filled_q[slot];
        data  = data_q[slot];
`ifdef PARC_ROB_FILL_COMMIT_BYPASS_EN
        if (!filled_q[slot] && fill_val && (fill_slot == slot)) begin
          ready = 1'b1;
          data  = fill_data;
        end
`endif
      end
    end
  end

  assign lookup0_hit   = g_lookup[0].hit;
  assign lookup0_slot  = g_lookup[0].slot;
  assign lookup0_ready = g_lookup[0].ready;
  assign lookup0_data  = g_lookup[0].data;
  assign lookup1_hit   = g_lookup[1].hit;
  assign lookup1_slot  = g_lookup[1].slot;
  assign lookup1_ready = g_lookup[1].ready;
  assign lookup1_data  = g_lookup[1].data;

endmodule
`default_nettype wire
